// File: rtl/spi_pkg.sv
// Shared definitions for the SPI serf: responder FSM states and default frame width.
package spi_pkg;

    typedef enum logic [1:0] {
        WAIT_DESEL = 2'd0,
        IDLE       = 2'd1,
        ARMED      = 2'd2,
        ACTIVE     = 2'd3
    } serf_state_t;

    localparam int SPI_WIDTH = 16;

endpackage

// File: rtl/spi_serf_rsp_sync_edge.sv
// Synchronizer chain with rise/fall detection on the two newest synced samples.
module sync_edge #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // Left unreset so that a reset during a frame still sees the true bus level.
    logic [SYNC:0] chain;

    always_ff @(posedge clk) begin
        chain <= {chain[SYNC-1:0], din};
    end

    assign level = chain[SYNC-1];
    assign rise  = chain[SYNC-1] & ~chain[SYNC];
    assign fall  = ~chain[SYNC-1] & chain[SYNC];

endmodule

// File: rtl/spi_serf_rsp.sv
// SPI responder: oversamples SS_n/SCLK/MOSI, captures a command word and shifts a
// preloaded response out on MISO.
module spi_serf_rsp
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH,
    parameter int SYNC  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             wrt,
    output logic [WIDTH-1:0] rx_data,
    output logic             rdy,
    input  logic             clr_rdy,
    output logic             frm_err
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH + 1);

    logic ss_lvl, rise_ss, fall_ss;
    logic sclk_lvl, rise_sclk, fall_sclk;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_sync;

    sync_edge #(.SYNC(SYNC)) u_ss (
        .clk   (clk),
        .din   (SS_n),
        .level (ss_lvl),
        .rise  (rise_ss),
        .fall  (fall_ss)
    );

    sync_edge #(.SYNC(SYNC)) u_sclk (
        .clk   (clk),
        .din   (SCLK),
        .level (sclk_lvl),
        .rise  (rise_sclk),
        .fall  (fall_sclk)
    );

    sync_edge #(.SYNC(SYNC)) u_mosi (
        .clk   (clk),
        .din   (MOSI),
        .level (mosi_lvl),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

    serf_state_t      state;
    logic [WIDTH-1:0] tx_buf;
    logic [WIDTH-1:0] tx_shft;
    logic [WIDTH-1:0] rx_shft;
    logic [CNT_W-1:0] count;
    logic             mosi_smpl;
    logic [WIDTH-1:0] rx_next;

    // The last sampled bit has not been shifted in yet when SS_n rises.
    assign rx_next = {rx_shft[WIDTH-2:0], mosi_smpl};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_DESEL;
            tx_buf    <= '0;
            tx_shft   <= '0;
            rx_shft   <= '0;
            rx_data   <= '0;
            count     <= '0;
            mosi_smpl <= 1'b0;
            rdy       <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            if (wrt)
                tx_buf <= tx_data;
            if (clr_rdy)
                rdy <= 1'b0;

            case (state)
                WAIT_DESEL: begin
                    if (ss_lvl)
                        state <= IDLE;
                end
                IDLE: begin
                    if (fall_ss) begin
                        tx_shft <= tx_buf;
                        count   <= '0;
                        rdy     <= 1'b0;
                        state   <= ARMED;
                    end
                end
                ARMED: begin
                    if (rise_ss) begin
                        frm_err <= 1'b1;
                        state   <= IDLE;
                    end else if (rise_sclk) begin
                        mosi_smpl <= mosi_lvl;
                        count     <= CNT_W'(1);
                        state     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (rise_ss) begin
                        rx_shft <= rx_next;
                        rx_data <= rx_next;
                        rdy     <= 1'b1;
                        frm_err <= (count != CNT_FULL);
                        state   <= IDLE;
                    end else begin
                        if (rise_sclk) begin
                            mosi_smpl <= mosi_lvl;
                            if (count != CNT_MAX)
                                count <= count + CNT_W'(1);
                        end
                        if (fall_sclk) begin
                            rx_shft <= rx_next;
                            tx_shft <= {tx_shft[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: state <= WAIT_DESEL;
            endcase
        end
    end

    assign MISO = (state == ARMED || state == ACTIVE) ? tx_shft[WIDTH-1] : 1'bz;

endmodule

// File: tb/tb_spi_serf_rsp.sv
// Directed bench for spi_serf_rsp: a behavioural 16-bit monarch drives frames and
// results are compared against hand-computed words.
module tb_spi_serf_rsp;

    logic        clk = 1'b0;
    logic        rst;
    logic        ss_n, sclk, mosi, wrt, clr_rdy;
    logic [15:0] tx_data, rx_data;
    logic        rdy, frm_err;
    wire         miso;

    int n_cmp = 0;
    int n_mis = 0;

    logic [15:0] rd;
    logic        rdy_mid;

    spi_serf_rsp #(.WIDTH(16), .SYNC(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .SS_n    (ss_n),
        .SCLK    (sclk),
        .MOSI    (mosi),
        .MISO    (miso),
        .tx_data (tx_data),
        .wrt     (wrt),
        .rx_data (rx_data),
        .rdy     (rdy),
        .clr_rdy (clr_rdy),
        .frm_err (frm_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [15:0] w);
        wrt = 1'b1;
        tx_data = w;
        clks(1);
        wrt = 1'b0;
    endtask

    // One monarch frame; leaves SS_n just raised with SCLK high.
    task automatic frame(input logic [15:0] w, input int nrises, input int rst_at,
                         input int wrt_at, input logic [15:0] wrt_word,
                         output logic [15:0] rd_word, output logic mid_rdy);
        logic [15:0] acc;
        acc = '0;
        ss_n = 1'b0;
        mosi = w[15];
        clks(8);
        mid_rdy = rdy;
        for (int i = 0; i < nrises; i++) begin
            sclk = 1'b0;
            if (i > 0) mosi = w[15-i];
            if (i == wrt_at) begin
                wrt = 1'b1;
                tx_data = wrt_word;
            end
            clks(1);
            wrt = 1'b0;
            clks(7);
            acc = {acc[14:0], miso};
            sclk = 1'b1;
            if (i == rst_at) rst = 1'b1;
            clks(1);
            rst = 1'b0;
            clks(7);
        end
        ss_n = 1'b1;
        rd_word = acc;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ss_n = 1'b1; sclk = 1'b1; mosi = 1'b1;
        wrt = 1'b0; clr_rdy = 1'b0; tx_data = '0;
        clks(10);
        rst = 1'b0;
        chk("rst_rdy", {15'd0, rdy}, 16'd0);
        chk("rst_rx", rx_data, 16'h0000);
        chk("rst_err", {15'd0, frm_err}, 16'd0);
        clks(5);

        // Basic exchange
        load_tx(16'h3C5A);
        frame(16'hA5C3, 16, -1, -1, 16'h0, rd, rdy_mid);
        clks(8);
        chk("t1_rx", rx_data, 16'hA5C3);
        chk("t1_rdy", {15'd0, rdy}, 16'd1);
        chk("t1_err", {15'd0, frm_err}, 16'd0);
        chk("t1_rd", rd, 16'h3C5A);

        // Back-to-back frames without clr_rdy
        frame(16'h0001, 16, -1, -1, 16'h0, rd, rdy_mid);
        clks(8);
        chk("t2a_rx", rx_data, 16'h0001);
        chk("t2a_rdy", {15'd0, rdy}, 16'd1);
        frame(16'hFFFF, 16, -1, -1, 16'h0, rd, rdy_mid);
        clks(8);
        chk("t2b_rdy_mid", {15'd0, rdy_mid}, 16'd0);
        chk("t2b_rx", rx_data, 16'hFFFF);
        chk("t2b_rdy", {15'd0, rdy}, 16'd1);
        chk("t2b_rd", rd, 16'h3C5A);

        // Short frame: 8 rises
        frame(16'h9600, 8, -1, -1, 16'h0, rd, rdy_mid);
        clks(8);
        chk("t3_err", {15'd0, frm_err}, 16'd1);
        chk("t3_rdy", {15'd0, rdy}, 16'd1);
        chk("t3_rx", rx_data, 16'hFF96);

        // Deselect before any rise
        frame(16'h1111, 0, -1, -1, 16'h0, rd, rdy_mid);
        clks(8);
        chk("t3b_err", {15'd0, frm_err}, 16'd1);
        chk("t3b_rdy", {15'd0, rdy}, 16'd0);
        chk("t3b_rx", rx_data, 16'hFF96);

        // Reset after the fifth rise
        frame(16'hF0F0, 16, 4, -1, 16'h0, rd, rdy_mid);
        clks(8);
        chk("t4_rdy", {15'd0, rdy}, 16'd0);
        chk("t4_rx", rx_data, 16'h0000);
        chk("t4_err", {15'd0, frm_err}, 16'd0);
        frame(16'h1234, 16, -1, -1, 16'h0, rd, rdy_mid);
        clks(8);
        chk("t4b_rx", rx_data, 16'h1234);
        chk("t4b_rdy", {15'd0, rdy}, 16'd1);
        chk("t4b_err", {15'd0, frm_err}, 16'd0);
        chk("t4b_rd", rd, 16'h0000);

        // wrt during a frame only affects the next frame
        load_tx(16'h0F0F);
        frame(16'hC001, 16, -1, 3, 16'hBEEF, rd, rdy_mid);
        clks(8);
        chk("t5a_rd", rd, 16'h0F0F);
        chk("t5a_rx", rx_data, 16'hC001);
        frame(16'h5555, 16, -1, -1, 16'h0, rd, rdy_mid);
        clks(8);
        chk("t5b_rd", rd, 16'hBEEF);
        chk("t5b_rx", rx_data, 16'h5555);

        // clr_rdy held across the completion cycle
        frame(16'h00FF, 16, -1, -1, 16'h0, rd, rdy_mid);
        clr_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            clks(1);
            if (rdy) break;
        end
        clr_rdy = 1'b0;
        chk("t6_set_wins", {15'd0, rdy}, 16'd1);
        clks(4);
        chk("t6_rdy_hold", {15'd0, rdy}, 16'd1);
        chk("t6_rx", rx_data, 16'h00FF);
        clr_rdy = 1'b1;
        clks(1);
        clr_rdy = 1'b0;
        clks(2);
        chk("t6_clr", {15'd0, rdy}, 16'd0);
        chk("t6_rx_kept", rx_data, 16'h00FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
